// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the alarm-clock mode controller.
//   state_t  : controller states
//   btn_t    : result of the per-cycle button priority encode
//   *_W      : BCD digit widths for the hour/minute fields
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    ADJ_TH = 3'd1,
    ADJ_TM = 3'd2,
    ADJ_AH = 3'd3,
    ADJ_AM = 3'd4,
    RING   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    BTN_NONE = 3'd0,
    BTN_C    = 3'd1,
    BTN_R    = 3'd2,
    BTN_L    = 3'd3,
    BTN_U    = 3'd4,
    BTN_D    = 3'd5
  } btn_t;

  localparam int unsigned H1_W              = 2;
  localparam int unsigned H2_W              = 4;
  localparam int unsigned M1_W              = 3;
  localparam int unsigned M2_W              = 4;
  localparam int unsigned RING_SECS_DEFAULT = 60;

  // Cyclic field order TH -> TM -> AH -> AM -> TH.
  function automatic state_t next_field(input state_t s);
    case (s)
      ADJ_TH:  return ADJ_TM;
      ADJ_TM:  return ADJ_AH;
      ADJ_AH:  return ADJ_AM;
      default: return ADJ_TH;
    endcase
  endfunction

  function automatic state_t prev_field(input state_t s);
    case (s)
      ADJ_TH:  return ADJ_AM;
      ADJ_TM:  return ADJ_TH;
      ADJ_AH:  return ADJ_TM;
      default: return ADJ_AH;
    endcase
  endfunction

endpackage

// File: rtl/clock_mode_controller_ring_timer.sv
// Ring duration counter.
//   clk, rst : clock, async active-low reset
//   clear    : hold counter at zero (asserted whenever not ringing)
//   tick     : count one second
//   done     : combinational; high on the tick that completes RING_SECS
module ring_timer #(
  parameter int unsigned RING_SECS = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam int unsigned       CNT_W = $clog2(RING_SECS + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(RING_SECS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flagged on the final tick itself so the FSM leaves RING one cycle later.
  assign done = tick & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/clock_mode_controller.sv
// Alarm-clock mode sequencer: button pulses -> mode/field enables and
// inc/dec strobes; alarm match edge detection and ringing sequence.
//   clk, rst           : clock, async active-low reset
//   sec_tick           : one-cycle pulse per second
//   btn_c/l/r/u/d      : debounced one-cycle button pulses
//   cur_*, alm_*       : current and alarm time, BCD digits
//   adjust, en_*       : adjust mode and one-hot field enables
//   en_s               : seconds clear after a time edit
//   inc, dec           : one-cycle strobes to the selected field
//   armed, ring        : alarm armed flag and ringing indicator
//   show_alarm         : display shows alarm time (alarm fields selected)
module clock_mode_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned RING_SECS = RING_SECS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sec_tick,
  input  logic            btn_c,
  input  logic            btn_l,
  input  logic            btn_r,
  input  logic            btn_u,
  input  logic            btn_d,
  input  logic [H1_W-1:0] cur_h1,
  input  logic [H2_W-1:0] cur_h2,
  input  logic [M1_W-1:0] cur_m1,
  input  logic [M2_W-1:0] cur_m2,
  input  logic [H1_W-1:0] alm_h1,
  input  logic [H2_W-1:0] alm_h2,
  input  logic [M1_W-1:0] alm_m1,
  input  logic [M2_W-1:0] alm_m2,
  output logic            adjust,
  output logic            en_th,
  output logic            en_tm,
  output logic            en_ah,
  output logic            en_am,
  output logic            en_s,
  output logic            inc,
  output logic            dec,
  output logic            armed,
  output logic            ring,
  output logic            show_alarm
);

  state_t state_q, state_d;
  btn_t   btn;
  logic   match, match_q, match_rise;
  logic   armed_q, armed_d, ring_q, ring_d;
  logic   inc_q, inc_d, dec_q, dec_d, en_s_q, en_s_d;
  logic   adjust_q, en_th_q, en_tm_q, en_ah_q, en_am_q, show_q;
  logic   rt_clear, rt_tick, rt_done;

  always_comb begin
    btn = BTN_NONE;
    if      (btn_c) btn = BTN_C;
    else if (btn_r) btn = BTN_R;
    else if (btn_l) btn = BTN_L;
    else if (btn_u) btn = BTN_U;
    else if (btn_d) btn = BTN_D;
  end

  assign match      = (cur_h1 == alm_h1) && (cur_h2 == alm_h2) &&
                      (cur_m1 == alm_m1) && (cur_m2 == alm_m2);
  assign match_rise = match & ~match_q;

  // A button in RING consumes the tick, so it is neither counted nor toggles.
  assign rt_clear = (state_q != RING);
  assign rt_tick  = (state_q == RING) && sec_tick && (btn == BTN_NONE);

  ring_timer #(
    .RING_SECS (RING_SECS)
  ) u_ring_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (rt_clear),
    .tick  (rt_tick),
    .done  (rt_done)
  );

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    ring_d  = ring_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (btn == BTN_C) begin
          state_d = ADJ_TH;
        end else if (match_rise && armed_q) begin
          state_d = RING;
          ring_d  = 1'b1;
        end else if (btn == BTN_U) begin
          armed_d = ~armed_q;
        end
      end
      ADJ_TH, ADJ_TM, ADJ_AH, ADJ_AM: begin
        case (btn)
          BTN_C:   state_d = RUN;
          BTN_R:   state_d = next_field(state_q);
          BTN_L:   state_d = prev_field(state_q);
          BTN_U:   inc_d   = 1'b1;
          BTN_D:   dec_d   = 1'b1;
          default: state_d = state_q;
        endcase
      end
      RING: begin
        if (btn != BTN_NONE || rt_done) begin
          state_d = RUN;
          ring_d  = 1'b0;
        end else if (sec_tick) begin
          ring_d = ~ring_q;
        end
      end
      default: begin
        state_d = RUN;
        ring_d  = 1'b0;
      end
    endcase
  end

  assign en_s_d = ((state_q == ADJ_TH) || (state_q == ADJ_TM)) && (state_d == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      match_q  <= 1'b0;
      armed_q  <= 1'b0;
      ring_q   <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      en_s_q   <= 1'b0;
      adjust_q <= 1'b0;
      en_th_q  <= 1'b0;
      en_tm_q  <= 1'b0;
      en_ah_q  <= 1'b0;
      en_am_q  <= 1'b0;
      show_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match;
      armed_q  <= armed_d;
      ring_q   <= ring_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      en_s_q   <= en_s_d;
      // Decoded from the next state so enables line up with the state change.
      adjust_q <= (state_d == ADJ_TH) || (state_d == ADJ_TM) ||
                  (state_d == ADJ_AH) || (state_d == ADJ_AM);
      en_th_q  <= (state_d == ADJ_TH);
      en_tm_q  <= (state_d == ADJ_TM);
      en_ah_q  <= (state_d == ADJ_AH);
      en_am_q  <= (state_d == ADJ_AM);
      show_q   <= (state_d == ADJ_AH) || (state_d == ADJ_AM);
    end
  end

  assign adjust     = adjust_q;
  assign en_th      = en_th_q;
  assign en_tm      = en_tm_q;
  assign en_ah      = en_ah_q;
  assign en_am      = en_am_q;
  assign en_s       = en_s_q;
  assign inc        = inc_q;
  assign dec        = dec_q;
  assign armed      = armed_q;
  assign ring       = ring_q;
  assign show_alarm = show_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller. Outputs are packed as
// {adjust, en_th, en_tm, en_ah, en_am, en_s, inc, dec, armed, ring, show_alarm}.
module tb_clock_mode_controller;
  import clock_ctrl_pkg::*;

  localparam logic [10:0] O_ADJ  = 11'h400;
  localparam logic [10:0] O_TH   = 11'h200;
  localparam logic [10:0] O_TM   = 11'h100;
  localparam logic [10:0] O_AH   = 11'h080;
  localparam logic [10:0] O_AM   = 11'h040;
  localparam logic [10:0] O_S    = 11'h020;
  localparam logic [10:0] O_INC  = 11'h010;
  localparam logic [10:0] O_DEC  = 11'h008;
  localparam logic [10:0] O_ARM  = 11'h004;
  localparam logic [10:0] O_RING = 11'h002;
  localparam logic [10:0] O_SHOW = 11'h001;

  localparam logic [10:0] X_TH = O_ADJ | O_TH;
  localparam logic [10:0] X_TM = O_ADJ | O_TM;
  localparam logic [10:0] X_AH = O_ADJ | O_AH | O_SHOW;
  localparam logic [10:0] X_AM = O_ADJ | O_AM | O_SHOW;

  // {c, r, l, u, d}
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sec_tick = 1'b0;
  logic btn_c = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic [H1_W-1:0] cur_h1, alm_h1;
  logic [H2_W-1:0] cur_h2, alm_h2;
  logic [M1_W-1:0] cur_m1, alm_m1;
  logic [M2_W-1:0] cur_m2, alm_m2;
  logic adjust, en_th, en_tm, en_ah, en_am, en_s, inc, dec, armed, ring, show_alarm;
  logic [10:0] outs;

  int unsigned n_asserts  = 0;
  int unsigned n_failures = 0;

  always #5 clk = ~clk;

  clock_mode_controller #(
    .RING_SECS (60)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sec_tick   (sec_tick),
    .btn_c      (btn_c),
    .btn_l      (btn_l),
    .btn_r      (btn_r),
    .btn_u      (btn_u),
    .btn_d      (btn_d),
    .cur_h1     (cur_h1),
    .cur_h2     (cur_h2),
    .cur_m1     (cur_m1),
    .cur_m2     (cur_m2),
    .alm_h1     (alm_h1),
    .alm_h2     (alm_h2),
    .alm_m1     (alm_m1),
    .alm_m2     (alm_m2),
    .adjust     (adjust),
    .en_th      (en_th),
    .en_tm      (en_tm),
    .en_ah      (en_ah),
    .en_am      (en_am),
    .en_s       (en_s),
    .inc        (inc),
    .dec        (dec),
    .armed      (armed),
    .ring       (ring),
    .show_alarm (show_alarm)
  );

  assign outs = {adjust, en_th, en_tm, en_ah, en_am, en_s, inc, dec, armed, ring, show_alarm};

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b);
    {btn_c, btn_r, btn_l, btn_u, btn_d} = b;
    step();
    {btn_c, btn_r, btn_l, btn_u, btn_d} = 5'b0;
  endtask

  task automatic set_cur(input logic [H1_W-1:0] h1, input logic [H2_W-1:0] h2,
                         input logic [M1_W-1:0] m1, input logic [M2_W-1:0] m2);
    cur_h1 = h1; cur_h2 = h2; cur_m1 = m1; cur_m2 = m2;
  endtask

  // 07:29 -> 07:30 against an alarm of 07:30
  task automatic approach_alarm();
    set_cur(2'd0, 4'd7, 3'd2, 4'd9);
    step();
    set_cur(2'd0, 4'd7, 3'd3, 4'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    alm_h1 = 2'd0; alm_h2 = 4'd7; alm_m1 = 3'd3; alm_m2 = 4'd0;
    set_cur(2'd1, 4'd2, 3'd0, 4'd0);
    step();
    step();
    check_eq("reset", outs, '0);
    rst = 1'b1;
    step();
    check_eq("idle", outs, '0);

    // Field navigation
    press(B_C); check_eq("c_to_th", outs, X_TH);
    press(B_R); check_eq("r_tm", outs, X_TM);
    press(B_R); check_eq("r_ah", outs, X_AH);
    press(B_R); check_eq("r_am", outs, X_AM);
    press(B_R); check_eq("r_wrap_th", outs, X_TH);
    press(B_L); check_eq("l_wrap_am", outs, X_AM);
    press(B_R); check_eq("r_am_th", outs, X_TH);
    press(B_R); check_eq("r_th_tm", outs, X_TM);

    // Single-cycle inc pulses
    for (int i = 0; i < 3; i++) begin
      press(B_U); check_eq("inc_pulse", outs, X_TM | O_INC);
      step();     check_eq("inc_low", outs, X_TM);
    end

    // Exit from time field clears seconds; from alarm field does not
    press(B_C); check_eq("exit_tm_en_s", outs, O_S);
    step();     check_eq("en_s_one_cycle", outs, '0);
    press(B_C); check_eq("reenter_th", outs, X_TH);
    press(B_R); check_eq("to_tm", outs, X_TM);
    press(B_R); check_eq("to_ah", outs, X_AH);
    press(B_C); check_eq("exit_ah_no_en_s", outs, '0);
    step();     check_eq("exit_ah_idle", outs, '0);

    // Priority: c over u, r over d
    press(B_C);       check_eq("enter_th", outs, X_TH);
    press(B_C | B_U); check_eq("c_beats_u", outs, O_S);
    step();           check_eq("c_beats_u_idle", outs, '0);
    press(B_C);       check_eq("enter_th2", outs, X_TH);
    press(B_R | B_D); check_eq("r_beats_d", outs, X_TM);
    press(B_D);       check_eq("dec_pulse", outs, X_TM | O_DEC);
    step();           check_eq("dec_low", outs, X_TM);
    press(B_C);       check_eq("exit_tm2", outs, O_S);
    step();           check_eq("exit_tm2_idle", outs, '0);

    // Disarmed: match edge gives no ring
    approach_alarm(); check_eq("disarmed_no_ring", outs, '0);
    step();           check_eq("disarmed_no_ring2", outs, '0);
    set_cur(2'd0, 4'd7, 3'd3, 4'd1);

    // Arm and ring until auto-stop
    press(B_U);       check_eq("arm", outs, O_ARM);
    approach_alarm(); check_eq("ring_start", outs, O_ARM | O_RING);
    sec_tick = 1'b1;
    for (int i = 1; i < 60; i++) begin
      step();
      check_eq("ring_toggle", outs, O_ARM | (((i % 2) == 0) ? O_RING : 11'h000));
    end
    step();
    sec_tick = 1'b0;
    check_eq("auto_stop", outs, O_ARM);
    step();
    check_eq("no_retrigger_held", outs, O_ARM);

    // Button silences ring without toggling armed
    approach_alarm(); check_eq("ring_again", outs, O_ARM | O_RING);
    press(B_U);       check_eq("silence_u", outs, O_ARM);
    step();           check_eq("silence_u_idle", outs, O_ARM);

    // Button coinciding with a tick in RING
    approach_alarm(); check_eq("ring_again2", outs, O_ARM | O_RING);
    btn_l = 1'b1; sec_tick = 1'b1;
    step();
    btn_l = 1'b0; sec_tick = 1'b0;
    check_eq("btn_beats_tick", outs, O_ARM);

    // Asynchronous reset mid-RING
    approach_alarm(); check_eq("ring_again3", outs, O_ARM | O_RING);
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
    check_eq("ring_tick_low", outs, O_ARM);
    #2 rst = 1'b0;
    #1 check_eq("async_reset", outs, '0);
    step();

    // Match held across reset release: no ring, even once armed
    rst = 1'b1;
    step();       check_eq("held_match_release", outs, '0);
    press(B_U);   check_eq("held_match_arm", outs, O_ARM);
    step();       check_eq("held_match_no_ring", outs, O_ARM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
    $finish;
  end

endmodule

// File: doc/clock_mode_controller.md
# clock_mode_controller

Central sequencer for the digital alarm clock. It turns one-cycle, debounced button pulses into the mode and field enables that drive the time and alarm counters (adjust, time-hour/minute, alarm-hour/minute, seconds clear) and the increment/decrement strobes. It also detects the alarm-time match and runs the ringing sequence. It sits between the button debouncers and the time/alarm datapath, and replaces the raw switch-driven enables at the top level.

## Interface
- RING_SECS, default 60: number of sec_tick pulses after which ringing stops automatically (1..255).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sec_tick  in  1  one-cycle pulse at each second boundary, synchronous to clk.
- btn_c, btn_l, btn_r, btn_u, btn_d  in  1 each  debounced button pulses, each one cycle wide.
- cur_h1, cur_h2, cur_m1, cur_m2  in  2/4/3/4  current time as BCD digits.
- alm_h1, alm_h2, alm_m1, alm_m2  in  2/4/3/4  alarm time as BCD digits.
- adjust  out  1  high in any ADJ_* state.
- en_th, en_tm, en_ah, en_am  out  1 each  one-hot field enable; high only in the matching ADJ_* state.
- en_s  out  1  one-cycle seconds-clear pulse.
- inc, dec  out  1 each  one-cycle increment/decrement strobes to the selected field.
- armed  out  1  alarm armed flag.
- ring  out  1  alarm indicator.
- show_alarm  out  1  display mux select; high in ADJ_AH and ADJ_AM.

## Operation
- States: RUN, ADJ_TH, ADJ_TM, ADJ_AH, ADJ_AM, RING. Encoded as state_t.
- Button priority per cycle: btn_c > btn_r > btn_l > btn_u > btn_d. Only the highest-priority asserted button is acted on; the rest are dropped, not queued.
- **RUN**
  - btn_c: go to ADJ_TH.
  - btn_u: toggle armed.
  - Other buttons: ignored.
- **ADJ_***
  - btn_r: next field, cyclic TH→TM→AH→AM→TH.
  - btn_l: previous field, cyclic.
  - btn_u: pulse inc.
  - btn_d: pulse dec.
  - btn_c: go to RUN.
- en_s pulses in the cycle after any transition into RUN from ADJ_TH or ADJ_TM (time was edited, so seconds are cleared). It does not pulse on exit from ADJ_AH or ADJ_AM.
- **Match detection**
  - match = (cur == alm) on all four digits.
  - match_q is the registered copy of match.
  - Ringing triggers only on a rising edge (match & ~match_q), in RUN, with armed=1.
  - A match present at reset release or on leaving adjust does not trigger, because match_q tracks match in every state.
- **RING**
  - Entry sets ring=1 and clears the ring counter.
  - Each sec_tick toggles ring and increments the counter.
  - Any button returns to RUN with ring=0 and armed unchanged. That button is consumed: a btn_u that silences the alarm does not also toggle armed.
  - When the counter reaches RING_SECS, return to RUN.
  - A rising match edge during RING is ignored.
- Reset values: state RUN; adjust, en_th, en_tm, en_ah, en_am, en_s, inc, dec, armed, ring and show_alarm all 0; match_q 0; counter 0.
- Reset asserted mid-RING or mid-adjust returns immediately, asynchronously, to the reset values.

## Timing
- All outputs are registered.
- Button pulse in cycle N: state change, enables, and inc/dec visible at cycle N+1.
- inc and dec are exactly one cycle wide per button pulse.
- en_s is high in the first cycle in which state==RUN after leaving ADJ_TH or ADJ_TM.
- Ringing: a match rising edge sampled at cycle N gives state=RING and ring=1 at N+1.
- Auto-stop: after the RING_SECS-th sec_tick in RING, state=RUN and ring=0 one cycle later.
- sec_tick coinciding with a button in RING: the button wins; ring=0 and there is no toggle.
- sec_tick coinciding with a match edge: trigger as normal. The tick is not counted toward RING_SECS.

## Structure
- Shared package clock_ctrl_pkg holds:
  - state_t (enum of the six states);
  - field width constants H1_W=2, H2_W=4, M1_W=3, M2_W=4;
  - RING_SECS_DEFAULT.
- One sub-module, ring_timer, wraps the RING_SECS counter:
  - inputs: clear, tick;
  - output: done;
  - counter width $clog2(RING_SECS+1).
- Everything else (FSM, priority encode, match edge logic) stays in the top module.

## Test plan
- Reset then btn_c → next cycle state=ADJ_TH, adjust=1, en_th=1.
- From ADJ_TH: btn_r ×4 → en_tm, en_ah, en_am, then en_th, one per pulse; btn_l from ADJ_TH → ADJ_AM, show_alarm=1.
- ADJ_TM: btn_u ×3 gives 3 single-cycle inc pulses. Then btn_c → RUN with a one-cycle en_s. Repeat the exit from ADJ_AH → no en_s.
- Simultaneous btn_c+btn_u in ADJ_TH → RUN, no inc pulse. Simultaneous btn_r+btn_d → ADJ_TM, no dec pulse.
- armed=1, alarm 07:30, cur steps 07:29→07:30 → ring=1 next cycle. 60 sec_ticks → ring toggles, then RUN with ring=0. With armed=0 the same stimulus gives no ring.
- In RING, drive btn_u → RUN, ring=0, armed stays 1. Assert rst mid-RING → all outputs 0 asynchronously. A cur==alm condition held across reset release → no ring.
